// File: rtl/draw_region_array.sv
`default_nettype none
// ============================================================================
// Module   : draw_region_array
// Purpose  : Multi-window region detector for the VGA drawing path. Holds
//            NUM_REGIONS programmable rectangles (filled or hollow border)
//            in a shadow bank. The shadow bank is copied into the active bank
//            at a frame start once a commit has been requested, so a frame
//            is never drawn from a half-updated set of rectangles. The
//            per-pixel hit test runs as a 2-stage pipeline.
// Ports    : clk_i / rst_n_i        pixel clock, synchronous active-low reset
//            pix_valid_i, x_i, y_i  pixel stream in
//            frame_start_i          frame boundary strobe (blanking)
//            cfg_*                  shadow write port (valid/ready) + commit
//            hit_o, any_o, idx_o    per-region hit, OR of hits, lowest hit
//            valid_o                pix_valid_i delayed by 2 cycles
// Revision : 1.0 - initial release
// ============================================================================
module draw_region_array #(
    parameter int NUM_REGIONS  = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int WindowWidth  = 640,
    parameter int WindowHeight = 480,
    parameter int BORDER_W     = 4,
    localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   pix_valid_i,
    input  logic [X_W-1:0]         x_i,
    input  logic [Y_W-1:0]         y_i,
    input  logic                   frame_start_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [IDX_W-1:0]       cfg_idx_i,
    input  logic [X_W-1:0]         cfg_x0_i,
    input  logic [X_W-1:0]         cfg_x1_i,
    input  logic [Y_W-1:0]         cfg_y0_i,
    input  logic [Y_W-1:0]         cfg_y1_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_border_i,
    input  logic                   cfg_commit_i,
    output logic [NUM_REGIONS-1:0] hit_o,
    output logic                   any_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   valid_o
);

    localparam logic [X_W-1:0] c_rst_x1  = X_W'(WindowWidth);
    localparam logic [Y_W-1:0] c_rst_y1  = Y_W'(WindowHeight);
    // Border thickness at one bit wider than the coordinates so that the
    // inner-edge sums/differences cannot wrap.
    localparam logic [X_W:0]   c_bx      = (X_W+1)'(BORDER_W);
    localparam logic [Y_W:0]   c_by      = (Y_W+1)'(BORDER_W);

    localparam logic [0:0]     c_st_idle = 1'b0;
    localparam logic [0:0]     c_st_pend = 1'b1;

    // ------------------------------------------------------------------
    // Region banks
    // ------------------------------------------------------------------
    logic [X_W-1:0]         r_shd_x0 [NUM_REGIONS];
    logic [X_W-1:0]         r_shd_x1 [NUM_REGIONS];
    logic [Y_W-1:0]         r_shd_y0 [NUM_REGIONS];
    logic [Y_W-1:0]         r_shd_y1 [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] r_shd_en;
    logic [NUM_REGIONS-1:0] r_shd_bd;

    logic [X_W-1:0]         r_act_x0 [NUM_REGIONS];
    logic [X_W-1:0]         r_act_x1 [NUM_REGIONS];
    logic [Y_W-1:0]         r_act_y0 [NUM_REGIONS];
    logic [Y_W-1:0]         r_act_y1 [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] r_act_en;
    logic [NUM_REGIONS-1:0] r_act_bd;

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       w_cfg_ready;
    logic       w_copy;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (cfg_commit_i)  w_state_next = c_st_pend;
            c_st_pend: if (frame_start_i) w_state_next = c_st_idle;
            default:                      w_state_next = c_st_idle;
        endcase
    end

    // A commit seen together with frame_start in IDLE only arms the FSM;
    // the copy is performed by the next frame_start seen in PENDING.
    always_comb begin
        w_cfg_ready = (r_state == c_st_idle);
        w_copy      = (r_state == c_st_pend) && frame_start_i;
    end

    assign cfg_ready_o = w_cfg_ready;

    // Writes only happen in IDLE and copies only in PENDING, so the two never
    // collide. An index beyond NUM_REGIONS matches no region and is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_shd_x0[i] <= '0;
                r_shd_y0[i] <= '0;
                r_shd_x1[i] <= (i == 0) ? c_rst_x1 : '0;
                r_shd_y1[i] <= (i == 0) ? c_rst_y1 : '0;
                r_act_x0[i] <= '0;
                r_act_y0[i] <= '0;
                r_act_x1[i] <= (i == 0) ? c_rst_x1 : '0;
                r_act_y1[i] <= (i == 0) ? c_rst_y1 : '0;
            end
            r_shd_en <= NUM_REGIONS'(1);
            r_act_en <= NUM_REGIONS'(1);
            r_shd_bd <= '0;
            r_act_bd <= '0;
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_valid_i && w_cfg_ready && (cfg_idx_i == IDX_W'(i))) begin
                    r_shd_x0[i] <= cfg_x0_i;
                    r_shd_x1[i] <= cfg_x1_i;
                    r_shd_y0[i] <= cfg_y0_i;
                    r_shd_y1[i] <= cfg_y1_i;
                    r_shd_en[i] <= cfg_en_i;
                    r_shd_bd[i] <= cfg_border_i;
                end
                if (w_copy) begin
                    r_act_x0[i] <= r_shd_x0[i];
                    r_act_x1[i] <= r_shd_x1[i];
                    r_act_y0[i] <= r_shd_y0[i];
                    r_act_y1[i] <= r_shd_y1[i];
                    r_act_en[i] <= r_shd_en[i];
                    r_act_bd[i] <= r_shd_bd[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-region hit test (half-open bounds)
    // ------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] w_hit;

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        logic [X_W:0] w_xl;
        logic [X_W:0] w_xr;
        logic [Y_W:0] w_yl;
        logic [Y_W:0] w_yr;
        logic         w_inside;
        logic         w_edge;

        // x1-B / y1-B clamp at 0 instead of wrapping to a huge value.
        assign w_xl = {1'b0, r_act_x0[gi]} + c_bx;
        assign w_yl = {1'b0, r_act_y0[gi]} + c_by;
        assign w_xr = ({1'b0, r_act_x1[gi]} >= c_bx) ? ({1'b0, r_act_x1[gi]} - c_bx) : '0;
        assign w_yr = ({1'b0, r_act_y1[gi]} >= c_by) ? ({1'b0, r_act_y1[gi]} - c_by) : '0;

        assign w_inside = r_act_en[gi]
                       && (x_i >= r_act_x0[gi]) && (x_i < r_act_x1[gi])
                       && (y_i >= r_act_y0[gi]) && (y_i < r_act_y1[gi]);

        assign w_edge = ({1'b0, x_i} < w_xl) || ({1'b0, x_i} >= w_xr)
                     || ({1'b0, y_i} < w_yl) || ({1'b0, y_i} >= w_yr);

        assign w_hit[gi] = w_inside && (!r_act_bd[gi] || w_edge);
    end

    // ------------------------------------------------------------------
    // Stage 1: registered compare results
    // ------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] r_s1_hit;
    logic                   r_s1_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1_hit   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_hit   <= pix_valid_i ? w_hit : '0;
            r_s1_valid <= pix_valid_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority encode and output registers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) w_idx = IDX_W'(i);
        end
    end

    logic [NUM_REGIONS-1:0] r_hit;
    logic                   r_any;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_hit   <= '0;
            r_any   <= 1'b0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_hit   <= r_s1_hit;
            r_any   <= |r_s1_hit;
            r_idx   <= w_idx;
            r_valid <= r_s1_valid;
        end
    end

    assign hit_o   = r_hit;
    assign any_o   = r_any;
    assign idx_o   = r_idx;
    assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_draw_region_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_region_array
// Purpose  : Self-checking bench for draw_region_array. A 4-region instance
//            is the main target; a 3-region instance shares the same stimulus
//            so that region index 3 is an out-of-range write for it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_draw_region_array;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int B  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, pix_valid, frame_start;
    logic          cfg_valid, cfg_en, cfg_border, cfg_commit;
    logic [XW-1:0] x, cfg_x0, cfg_x1;
    logic [YW-1:0] y, cfg_y0, cfg_y1;
    logic [1:0]    cfg_idx;

    logic          ready_a, any_a, valid_a;
    logic [3:0]    hit_a;
    logic [1:0]    idx_a;
    logic          ready_b, any_b, valid_b;
    logic [2:0]    hit_b;
    logic [1:0]    idx_b;

    draw_region_array #(.NUM_REGIONS(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .pix_valid_i(pix_valid), .x_i(x), .y_i(y),
        .frame_start_i(frame_start), .cfg_valid_i(cfg_valid), .cfg_ready_o(ready_a),
        .cfg_idx_i(cfg_idx), .cfg_x0_i(cfg_x0), .cfg_x1_i(cfg_x1),
        .cfg_y0_i(cfg_y0), .cfg_y1_i(cfg_y1), .cfg_en_i(cfg_en),
        .cfg_border_i(cfg_border), .cfg_commit_i(cfg_commit),
        .hit_o(hit_a), .any_o(any_a), .idx_o(idx_a), .valid_o(valid_a)
    );

    draw_region_array #(.NUM_REGIONS(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .pix_valid_i(pix_valid), .x_i(x), .y_i(y),
        .frame_start_i(frame_start), .cfg_valid_i(cfg_valid), .cfg_ready_o(ready_b),
        .cfg_idx_i(cfg_idx), .cfg_x0_i(cfg_x0), .cfg_x1_i(cfg_x1),
        .cfg_y0_i(cfg_y0), .cfg_y1_i(cfg_y1), .cfg_en_i(cfg_en),
        .cfg_border_i(cfg_border), .cfg_commit_i(cfg_commit),
        .hit_o(hit_b), .any_o(any_b), .idx_o(idx_b), .valid_o(valid_b)
    );

    // ------------------------------------------------------------------
    // Reference model: rectangles as plain integers, banks as arrays.
    // ------------------------------------------------------------------
    typedef struct { int x0; int y0; int x1; int y1; bit en; bit bd; } reg_t;
    typedef struct { bit v; int x; int y; bit fs; } pix_t;

    reg_t act[4];
    reg_t shd[4];
    bit   pend;

    logic [7:0] exp_a_q[$];   // {hit[3:0], any, idx[1:0], valid}
    logic [6:0] exp_b_q[$];   // {hit[2:0], any, idx[1:0], valid}
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) shd[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
        shd[0] = '{0, 0, 640, 480, 1'b1, 1'b0};
        act    = shd;
        pend   = 1'b0;
    endfunction

    function automatic logic [3:0] model_hits(int px, int py);
        logic [3:0] h = '0;
        for (int i = 0; i < 4; i++) begin
            bit in_r = act[i].en && px >= act[i].x0 && px < act[i].x1
                                 && py >= act[i].y0 && py < act[i].y1;
            if (in_r && act[i].bd)
                in_r = (px < act[i].x0 + B) || (px >= act[i].x1 - B) ||
                       (py < act[i].y0 + B) || (py >= act[i].y1 - B);
            h[i] = in_r;
        end
        return h;
    endfunction

    function automatic logic [1:0] lowest(logic [3:0] h);
        logic [1:0] r = '0;
        for (int i = 3; i >= 0; i--) if (h[i]) r = 2'(i);
        return r;
    endfunction

    function automatic pix_t pt(int px, int py, bit fs = 1'b0);
        pix_t p;
        p.v = 1'b1; p.x = px; p.y = py; p.fs = fs;
        return p;
    endfunction

    function automatic pix_t rpt(int xl, int xh, int yl, int yh);
        pix_t p;
        p.v  = ($urandom_range(5, 0) != 0);
        p.x  = int'($urandom_range(xh, xl));
        p.y  = int'($urandom_range(yh, yl));
        p.fs = 1'b0;
        return p;
    endfunction

    // One clock: advance the model with the inputs currently driven, then
    // wait for the edge and step 1 ns past it.
    task automatic tick();
        if (!rst_n) begin
            model_reset();
        end else if (!pend) begin
            if (cfg_valid)
                shd[cfg_idx] = '{int'(cfg_x0), int'(cfg_y0), int'(cfg_x1), int'(cfg_y1),
                                 cfg_en, cfg_border};
            if (cfg_commit) pend = 1'b1;
        end else if (frame_start) begin
            act  = shd;
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input pix_t p);
        logic [3:0] h;
        pix_valid   = p.v;
        x           = XW'(p.x);
        y           = YW'(p.y);
        frame_start = p.fs;
        h = p.v ? model_hits(p.x, p.y) : 4'b0;
        exp_a_q.push_back({h, |h, lowest(h), p.v});
        exp_b_q.push_back({h[2:0], |h[2:0], lowest({1'b0, h[2:0]}), p.v});
    endtask

    task automatic cfg_write(input int idx, input int x0, input int y0,
                             input int x1, input int y1, input bit en, input bit bd);
        cfg_idx = 2'(idx); cfg_x0 = XW'(x0); cfg_y0 = YW'(y0);
        cfg_x1 = XW'(x1); cfg_y1 = YW'(y1); cfg_en = en; cfg_border = bd;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; x = '0; y = '0;
        cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_border = 1'b0; cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0;
        repeat (3) tick();
        n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_a); end
        n_cmp++; if (hit_a !== 4'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0000", hit_a); end
        n_cmp++; if (any_a !== 1'b0) begin n_fail++; $display("FAIL reset_any: got %b want 0", any_a); end
        n_cmp++; if (idx_a !== 2'b0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_cmp++; if ({ready_b, hit_b, any_b, idx_b, valid_b} !== 8'b1000_0000) begin
            n_fail++; $display("FAIL reset_dut3: got %b want 10000000", {ready_b, hit_b, any_b, idx_b, valid_b});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        pts = '{pt(0, 0), pt(639, 0), pt(0, 479), pt(639, 479), pt(640, 0),
                pt(0, 480), pt(640, 480), pt(320, 240), pt(1023, 511)};
        for (int k = 0; k < 200; k++) pts.push_back(rpt(0, 700, 0, 511));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL sweep pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL sweep_dut3 pix%0d: got %b want %b", k-1, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    task automatic test_fill();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        cfg_write(2, 100, 50, 200, 150, 1'b1, 1'b0);
        pulse_commit();
        n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL fill_ready_fall: got %b want 0", ready_a); end
        // Before the frame start region 2 must stay invisible; the pixel
        // sharing the frame_start cycle still sees the old bank.
        pts = '{pt(100, 50), pt(150, 100), pt(199, 149), pt(100, 50, 1'b1),
                pt(100, 50), pt(199, 149), pt(200, 149), pt(199, 150), pt(99, 50), pt(100, 49)};
        for (int k = 0; k < 40; k++) pts.push_back(rpt(90, 210, 40, 160));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL fill pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL fill_dut3 pix%0d: got %b want %b", k-1, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
        n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL fill_ready_rise: got %b want 1", ready_a); end
    endtask

    task automatic test_border();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        cfg_write(1, 10, 10, 30, 30, 1'b1, 1'b1);
        pulse_commit();
        pulse_frame();
        pts = '{pt(13, 20), pt(14, 20), pt(26, 20), pt(25, 20), pt(20, 20), pt(20, 26),
                pt(20, 13), pt(20, 14), pt(10, 10), pt(29, 29), pt(30, 20), pt(9, 20)};
        for (int k = 0; k < 60; k++) pts.push_back(rpt(0, 40, 0, 40));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL border pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL border_dut3 pix%0d: got %b want %b", k-1, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    task automatic test_stall();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        pulse_commit();
        n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL stall_ready_fall: got %b want 0", ready_a); end
        // Hold a write for region 3 through the stall; it must not land.
        cfg_idx = 2'd3; cfg_x0 = 10'd500; cfg_y0 = 9'd300; cfg_x1 = 10'd600; cfg_y1 = 9'd400;
        cfg_en = 1'b1; cfg_border = 1'b0; cfg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL stall_ready_held%0d: got %b want 0", k, ready_a); end
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0; cfg_valid = 1'b0;
        n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL stall_ready_rise: got %b want 1", ready_a); end
        // Then write region 3 properly and commit coincident with frame_start:
        // the copy must wait for the following frame_start.
        cfg_write(3, 500, 300, 600, 400, 1'b1, 1'b0);
        cfg_commit = 1'b1; frame_start = 1'b1;
        tick();
        cfg_commit = 1'b0; frame_start = 1'b0;
        n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL coinc_pending: got %b want 0", ready_a); end
        pts = '{pt(550, 350), pt(500, 300), pt(599, 399), pt(550, 350, 1'b1),
                pt(550, 350), pt(500, 300), pt(599, 399), pt(600, 399), pt(599, 400)};
        for (int k = 0; k < 40; k++) pts.push_back(rpt(450, 650, 250, 450));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL stall pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL stall_dut3 pix%0d: got %b want %b", k-1, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    task automatic test_edges();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        cfg_write(1, 300, 300, 300, 400, 1'b1, 1'b0);   // zero width
        cfg_write(3, 630, 470, 640, 480, 1'b1, 1'b1);   // out of range for dut3
        cfg_write(2, 0, 0, 3, 3, 1'b1, 1'b1);           // x1-B, y1-B underflow
        pulse_commit();
        pulse_frame();
        pts = '{pt(639, 479), pt(635, 475), pt(634, 474), pt(636, 476), pt(630, 470),
                pt(633, 477), pt(300, 350), pt(299, 350), pt(1, 1), pt(2, 2), pt(3, 3), pt(0, 0)};
        for (int k = 0; k < 40; k++) pts.push_back(rpt(600, 700, 440, 511));
        for (int k = 0; k < 20; k++) pts.push_back(rpt(0, 10, 0, 10));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL edges pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL edges_dut3 pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    task automatic test_reset_pending();
        pix_t pts[$];
        logic [7:0] ea; logic [6:0] eb;
        cfg_write(0, 200, 200, 300, 300, 1'b1, 1'b0);
        pulse_commit();
        n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL rstpend_ready_fall: got %b want 0", ready_a); end
        // Put a hitting pixel in flight so the reset has something to clear.
        pix_valid = 1'b1; x = 10'd10; y = 9'd10;
        tick();
        pix_valid = 1'b0; rst_n = 1'b0;
        tick();
        n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rstpend_ready: got %b want 1", ready_a); end
        n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== 8'b0) begin
            n_fail++; $display("FAIL rstpend_outputs: got %b want 00000000", {hit_a, any_a, idx_a, valid_a});
        end
        rst_n = 1'b1;
        pts = '{pt(250, 250), pt(100, 100), pt(639, 479), pt(640, 479), pt(0, 0), pt(10, 10)};
        for (int k = 0; k < 40; k++) pts.push_back(rpt(0, 700, 0, 511));
        for (int k = 0; k <= pts.size(); k++) begin
            if (k < pts.size()) drive_pix(pts[k]); else drive_pix('{1'b0, 0, 0, 1'b0});
            tick();
            if (exp_a_q.size() == 2) begin
                ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
                n_cmp++; if ({hit_a, any_a, idx_a, valid_a} !== ea) begin
                    n_fail++; $display("FAIL rstpend pix%0d (%0d,%0d): got %b want %b", k-1, pts[k-1].x, pts[k-1].y, {hit_a, any_a, idx_a, valid_a}, ea);
                end
                n_cmp++; if ({hit_b, any_b, idx_b, valid_b} !== eb) begin
                    n_fail++; $display("FAIL rstpend_dut3 pix%0d: got %b want %b", k-1, {hit_b, any_b, idx_b, valid_b}, eb);
                end
            end
        end
        exp_a_q.delete(); exp_b_q.delete();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_fill();
        test_border();
        test_stall();
        test_edges();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/draw_region_array.md
# draw_region_array

Parametrised multi-window region detector for the VGA drawing path; generalises the single fixed game-window test to `NUM_REGIONS` runtime-programmable rectangles. Each rectangle can be drawn filled or as a hollow border. Rectangles are written into a shadow bank and committed atomically at a frame boundary, so no tearing occurs mid-frame. Per-pixel results are pipelined (2 cycles) and feed the colour mux downstream of the VGA timing generator.

## Interface
Parameters:
- `NUM_REGIONS`, 4: number of rectangles, 1..16.
- `X_W`, 10: x coordinate width.
- `Y_W`, 9: y coordinate width.
- `WindowWidth`, 640: reset x1 of region 0.
- `WindowHeight`, 480: reset y1 of region 0.
- `BORDER_W`, 4: border thickness in pixels for border-mode regions.

Ports:
- `clk_i`, input, 1: pixel clock.
- `rst_n_i`, input, 1: synchronous active-low reset.
- `pix_valid_i`, input, 1: `x_i`/`y_i` carry an active pixel this cycle.
- `x_i`, input, X_W: pixel x.
- `y_i`, input, Y_W: pixel y.
- `frame_start_i`, input, 1: single-cycle strobe at the start of the frame (blanking).
- `cfg_valid_i`, input, 1: shadow write request.
- `cfg_ready_o`, output, 1: shadow write accepted when high with `cfg_valid_i`.
- `cfg_idx_i`, input, clog2(NUM_REGIONS) (min 1): region written.
- `cfg_x0_i`, `cfg_x1_i`, input, X_W each: x bounds.
- `cfg_y0_i`, `cfg_y1_i`, input, Y_W each: y bounds.
- `cfg_en_i`, input, 1: region enable.
- `cfg_border_i`, input, 1: 1 = border mode, 0 = fill.
- `cfg_commit_i`, input, 1: request shadow→active copy at the next frame start.
- `hit_o`, output, NUM_REGIONS: per-region hit.
- `any_o`, output, 1: OR of `hit_o`.
- `idx_o`, output, clog2(NUM_REGIONS): lowest-index hit, 0 when none.
- `valid_o`, output, 1: `pix_valid_i` delayed by 2 cycles.

## Operation
- Reset state: region 0 active and shadow = (0, 0, WindowWidth, WindowHeight), enabled, fill. All other regions are disabled with zero bounds. `cfg_ready_o` = 1, commit pending = 0, and all outputs are 0.
- Hit test uses half-open bounds: inside = x0 ≤ x < x1 and y0 ≤ y < y1 and en. A region with x1 ≤ x0 or y1 ≤ y0 never hits.
- Border mode: hit = inside and (x < x0+B or x ≥ x1−B or y < y0+B or y ≥ y1−B), where B = BORDER_W. Sums and differences are computed one bit wider than the operand so there is no wrap. x1−B underflow is treated as 0. A region narrower than 2B is fully hit.
- Shadow writes: when `cfg_valid_i` and `cfg_ready_o` are both high, write all fields of shadow[`cfg_idx_i`]. An out-of-range idx is accepted and discarded.
- Commit FSM, two states:
  - IDLE: `cfg_ready_o`=1. `cfg_commit_i` moves the FSM to PENDING.
  - PENDING: `cfg_ready_o`=0 and writes are stalled. On `frame_start_i`, copy the entire shadow bank to active and return to IDLE.
- A commit in the same cycle as a write: the write lands first, then the FSM enters PENDING.
- A commit in the same cycle as `frame_start_i` while in IDLE: the copy waits for the next `frame_start_i`.
- `cfg_commit_i` while already PENDING is ignored.
- Reset while PENDING drops the pending commit and restores the reset bank.
- Pixels when `pix_valid_i`=0 still advance the pipeline. Their `hit_o`, `any_o`, and `idx_o` are forced to 0.

## Timing
- Stage 1 (registered): per-region compare against the active bank.
- Stage 2 (registered): `hit_o`, `any_o`, `idx_o` priority encode, and `valid_o`.
- Latency is 2 cycles from `x_i`/`y_i` to outputs, with throughput of 1 pixel per cycle.
- The active-bank copy becomes visible to the pixel presented in the cycle after `frame_start_i`.
- `cfg_ready_o` falls in the cycle after commit is sampled. It rises in the cycle after the `frame_start_i` that performs the copy.

## Test plan
- Reset, then a full-frame sweep. Require `hit_o`=0001 exactly for 0≤x<640, 0≤y<480, and valid_o 2 cycles after pix_valid_i. At (640,0) and (0,480), require hit 0.
- Write region 2 as (100,50,200,150) fill, commit, and pulse frame_start. Then (100,50) → hit_o=0101, idx_o=0. (199,149) → hit. (200,149) → region 2 not hit. Before the frame_start, region 2 never hits.
- Region 1 = (10,10,30,30), border, B=4. (13,20) → hit. (14,20) → no hit. (26,20) → hit. (20,20) → no hit. (20,26) → hit.
- Commit asserted, then cfg_valid held high. Require cfg_ready_o=0 until the cycle after frame_start, with no shadow change during the stall. Commit coincident with frame_start → the copy occurs only on the second frame_start.
- Degenerate and edge regions: x1=x0 → never hit. Region at (630,470,640,480) border → (639,479) hit, and B arithmetic does not wrap. Out-of-range cfg_idx_i is ignored.
- Assert rst_n_i low mid-PENDING with region 0 reprogrammed. Require region 0 to return to the full window, cfg_ready_o=1, and outputs 0 in the cycle after reset.
